// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: turns EX/MEM load/store requests into word-aligned
// data-memory bus transactions and returns extended load data toward MEM/WB.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic        flush,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned    CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          kill, kill_nx;
    logic [1:0]    off_q, off_nx;
    logic [2:0]    f3_q, f3_nx;

    logic          req_nx, we_nx, done_nx, mis_nx, err_nx;
    logic [31:0]   addr_nx, wdata_nx, ld_nx;
    logic [3:0]    be_nx;

    logic          acc, illegal, fault, kill_eff;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c, shifted, ext;

    assign acc = valid & ~flush & (mem_read | mem_write);

    always_comb begin
        illegal = 1'b1;
        case (funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = ~mem_read;
            default:                illegal = 1'b1;
        endcase
        fault = illegal
              | ((funct3[1:0] == 2'b01) & addr[0])
              | ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    end

    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << addr[1:0];
                wdata_c = {2{store_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = store_data;
            end
        endcase
    end

    // Load extraction uses the offset/width captured at launch, not live EX/MEM inputs.
    always_comb begin
        shifted = dm_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'h0, shifted[7:0]};
            3'b101:  ext = {16'h0, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign stall    = ((state == IDLE) & acc & ~fault) | (state == BUSY);
    assign kill_eff = kill | flush;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        kill_nx  = kill;
        off_nx   = off_q;
        f3_nx    = f3_q;
        req_nx   = dm_req;
        we_nx    = dm_we;
        addr_nx  = dm_addr;
        be_nx    = dm_be;
        wdata_nx = dm_wdata;
        ld_nx    = load_data;
        done_nx  = 1'b0;
        mis_nx   = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (acc) begin
                    if (fault) begin
                        mis_nx = 1'b1;
                    end else begin
                        req_nx   = 1'b1;
                        we_nx    = ~mem_read;
                        addr_nx  = {addr[31:2], 2'b00};
                        be_nx    = be_c;
                        wdata_nx = wdata_c;
                        off_nx   = addr[1:0];
                        f3_nx    = funct3;
                        cnt_nx   = '0;
                        kill_nx  = 1'b0;
                        state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                kill_nx = kill_eff;
                if (dm_ack) begin
                    req_nx   = 1'b0;
                    state_nx = DONE;
                    if (!kill_eff) begin
                        done_nx = 1'b1;
                        if (!dm_we) ld_nx = ext;
                    end
                end else if (cnt == CNT_LAST) begin
                    req_nx   = 1'b0;
                    state_nx = DONE;
                    if (!kill_eff) begin
                        done_nx = 1'b1;
                        err_nx  = 1'b1;
                        ld_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            DONE: begin
                kill_nx  = 1'b0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            kill      <= 1'b0;
            off_q     <= '0;
            f3_q      <= '0;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_be     <= '0;
            dm_wdata  <= '0;
            load_data <= '0;
            done      <= 1'b0;
            misalign  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            kill      <= kill_nx;
            off_q     <= off_nx;
            f3_q      <= f3_nx;
            dm_req    <= req_nx;
            dm_we     <= we_nx;
            dm_addr   <= addr_nx;
            dm_be     <= be_nx;
            dm_wdata  <= wdata_nx;
            load_data <= ld_nx;
            done      <= done_nx;
            misalign  <= mis_nx;
            bus_err   <= err_nx;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized checks of mem_access_unit against an arithmetic reference
// model of width legality, byte lanes, extension, timeout and flush behaviour.
module tb_mem_access_unit;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, flush, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [31:0] load_data;
    logic        done, stall, misalign, bus_err;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_ld = 32'h0;

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .store_data(store_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .load_data(load_data), .done(done), .stall(stall),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Access size in bytes for a legal code, 0 when the code is illegal.
    function automatic int acc_size(input bit ld, input logic [2:0] f3);
        case (f3)
            3'd0: return 1;
            3'd1: return 2;
            3'd2: return 4;
            3'd4: return ld ? 1 : 0;
            3'd5: return ld ? 2 : 0;
            default: return 0;
        endcase
    endfunction

    task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] sd,
                              input logic [31:0] rdata, input int ack_k, input int flush_k);
        bit          ld       = rd;
        int          size     = acc_size(ld, f3);
        int          o        = int'(a % 4);
        bit          fault    = (size == 0) || ((a % size) != 0);
        longint      mask     = (size == 4) ? 64'hFFFF_FFFF : ((64'd1 << (8 * size)) - 1);
        logic [3:0]  exp_be   = 4'(((1 << size) - 1) << o);
        logic [31:0] exp_wd;
        longint      v;
        int          ev       = 0;
        bit          killed, timed_out;

        if (size == 1)      exp_wd = (sd & 32'hFF) * 32'h0101_0101;
        else if (size == 2) exp_wd = (sd & 32'hFFFF) * 32'h0001_0001;
        else                exp_wd = sd;

        @(negedge clk);
        valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
        #1;
        chk("stall_launch", 32'(stall), 32'(!fault));
        @(negedge clk);
        if (fault) begin
            chk("misalign_pulse", 32'(misalign), 32'd1);
            chk("fault_no_req", 32'(dm_req), 32'd0);
            chk("fault_no_stall", 32'(stall), 32'd0);
            valid = 1'b0;
            @(negedge clk);
            chk("misalign_clear", 32'(misalign), 32'd0);
            chk("fault_no_req2", 32'(dm_req), 32'd0);
            return;
        end
        chk("dm_addr", dm_addr, a & 32'hFFFF_FFFC);
        chk("dm_be", 32'(dm_be), 32'(exp_be));
        chk("dm_we", 32'(dm_we), 32'(!ld));
        if (!ld) chk("dm_wdata", dm_wdata, exp_wd);
        for (int k = 1; k <= TMO; k++) begin
            chk("busy_req", 32'(dm_req), 32'd1);
            chk("busy_stall", 32'(stall), 32'd1);
            dm_ack   = (k == ack_k);
            dm_rdata = (k == ack_k) ? rdata : 32'h0;
            flush    = (k == flush_k);
            @(negedge clk);
            dm_ack = 1'b0; dm_rdata = 32'h0; flush = 1'b0;
            if (k == ack_k) begin
                ev = k;
                break;
            end
        end
        timed_out = (ev == 0);
        if (timed_out) ev = TMO;
        killed = (flush_k >= 1) && (flush_k <= ev);

        if (!killed) begin
            if (timed_out) model_ld = 32'h0;
            else if (ld) begin
                v = (longint'(rdata) >> (8 * o)) & mask;
                if (f3 inside {3'd0, 3'd1} && ((v >> (8 * size - 1)) & 1) == 1) v = v | (~mask);
                model_ld = 32'(v);
            end
        end
        chk("done_pulse", 32'(done), 32'(!killed));
        chk("bus_err", 32'(bus_err), 32'(timed_out && !killed));
        chk("load_data", load_data, model_ld);
        chk("done_req_low", 32'(dm_req), 32'd0);
        chk("done_no_stall", 32'(stall), 32'd0);
        valid = 1'b0;
        @(negedge clk);
        chk("done_clear", 32'(done), 32'd0);
        chk("err_clear", 32'(bus_err), 32'd0);
        chk("idle_req", 32'(dm_req), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'h0; store_data = 32'h0; dm_ack = 1'b0; dm_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(dm_req), 32'd0);
        chk("rst_be", 32'(dm_be), 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_flags", {28'd0, done, misalign, bus_err, stall}, 32'd0);
        rst_n = 1'b1;

        run_access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 0);
        run_access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, 0);
        run_access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 0);
        run_access(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 32'h0, 2, 0);
        run_access(1, 0, 3'b001, 32'h101, 32'h0, 32'h0, 1, 0);
        run_access(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 0);
        run_access(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 1, 0);
        run_access(1, 0, 3'b010, 32'h300, 32'h0, 32'h1111_2222, 0, 0);
        run_access(1, 0, 3'b010, 32'h304, 32'h0, 32'h3333_4444, TMO, 0);
        run_access(1, 1, 3'b101, 32'h402, 32'h0, 32'h8001_7F00, 3, 0);
        run_access(1, 0, 3'b010, 32'h500, 32'h0, 32'h0000_0055, 2, 1);

        for (int n = 0; n < 80; n++) begin
            int          kind = $urandom_range(0, 2);
            logic [2:0]  f3;
            logic [31:0] a = $urandom;
            int          ak = $urandom_range(1, 20);
            int          fk = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
            if ($urandom_range(0, 3) != 0) begin
                logic [2:0] legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
                f3 = legal[$urandom_range(0, 4)];
            end else begin
                f3 = 3'($urandom);
            end
            if ($urandom_range(0, 2) != 0) a[1:0] = (f3[1:0] == 2'b10) ? 2'b00 :
                                                    (f3[1:0] == 2'b01) ? {a[1], 1'b0} : a[1:0];
            if (ak > 18) ak = 0;
            run_access(kind != 1, kind != 0, f3, a, $urandom, $urandom, ak, fk);
        end

        @(negedge clk);
        valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h600;
        @(negedge clk);
        chk("pre_rst_req", 32'(dm_req), 32'd1);
        valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(dm_req), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_load", load_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("no_resume_req", 32'(dm_req), 32'd0);
        chk("no_resume_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
